sys_reset_ce: RTL and testbench



---
 rtl/sys_reset_ce.sv | 167 ++++++++++++++++
 tb/tb_sys_reset_ce.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_reset_ce.sv
// Reset sequencer and clock-enable generator for the ZX81 core.
// Waits for a stable PLL lock, holds the core in reset for a short
// window while the enables already run, and re-enters reset on lock
// loss or on a debounced user button press.
module sys_reset_ce #(
  parameter int unsigned LOCK_WAIT  = 1024,
  parameter int unsigned RST_HOLD   = 16,
  parameter int unsigned DEB_CYCLES = 65536,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned CPU_DIV    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic btn_reset,
  output logic sys_rst_n,
  output logic ce_pix,
  output logic ce_cpu,
  output logic running
);

  localparam int unsigned CNT_MAX = (LOCK_WAIT > RST_HOLD) ? LOCK_WAIT : RST_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PIX_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned CPU_W   = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [1:0]       lock_sync;
  logic [1:0]       btn_sync;
  logic             lock_s;
  logic             btn_s;
  logic             btn_db;
  logic             btn_db_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             div_run;
  logic [PIX_W-1:0] pix_cnt;
  logic [CPU_W-1:0] cpu_cnt;

  // Two metastability flops per async input, then the registered synchronized value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= 2'b00;
      btn_sync  <= 2'b00;
      lock_s    <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      btn_sync  <= {btn_sync[0], btn_reset};
      lock_s    <= lock_sync[1];
      btn_s     <= btn_sync[1];
    end
  end

  // Button debouncer: accept a new level only after DEB_CYCLES stable samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        btn_db  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  // Next-state and shared counter; lock loss outranks a button press
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT: begin
        if (lock_s) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT;
        end else if (cnt == CNT_W'(LOCK_WAIT - 1)) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT;
        end else if (cnt == CNT_W'(RST_HOLD - 1)) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT;
        end else if (press) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Dividers advance only while staying in HOLD/RUN; every HOLD entry realigns them
  assign div_run = ((state_nxt == ST_HOLD) || (state_nxt == ST_RUN)) &&
                   !((state_nxt == ST_HOLD) && (state != ST_HOLD));

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT;
      cnt       <= '0;
      pix_cnt   <= '0;
      cpu_cnt   <= '0;
      ce_pix    <= 1'b0;
      ce_cpu    <= 1'b0;
      sys_rst_n <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sys_rst_n <= (state_nxt == ST_RUN);
      running   <= (state_nxt == ST_RUN);
      if (div_run) begin
        pix_cnt <= (pix_cnt == PIX_W'(PIX_DIV - 1)) ? '0 : pix_cnt + PIX_W'(1);
        cpu_cnt <= (cpu_cnt == CPU_W'(CPU_DIV - 1)) ? '0 : cpu_cnt + CPU_W'(1);
        ce_pix  <= (pix_cnt == PIX_W'(PIX_DIV - 1));
        ce_cpu  <= (cpu_cnt == CPU_W'(CPU_DIV - 1));
      end else begin
        pix_cnt <= '0;
        cpu_cnt <= '0;
        ce_pix  <= 1'b0;
        ce_cpu  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sys_reset_ce.sv
// Self-checking bench for sys_reset_ce: vector table, directed corner
// sequences and random lock/button activity against a reference model.
module tb_sys_reset_ce;

  localparam int unsigned LW  = 8;
  localparam int unsigned RH  = 4;
  localparam int unsigned DEB = 16;
  localparam int unsigned PIX = 2;
  localparam int unsigned CPU = 4;

  localparam int S_WAIT   = 0;
  localparam int S_SETTLE = 1;
  localparam int S_HOLD   = 2;
  localparam int S_RUN    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_locked = 1'b0;
  logic btn_reset = 1'b0;
  logic sys_rst_n, ce_pix, ce_cpu, running;

  int errors = 0;
  int checks = 0;
  int edge_no = -1;

  sys_reset_ce #(
    .LOCK_WAIT (LW),
    .RST_HOLD  (RH),
    .DEB_CYCLES(DEB),
    .PIX_DIV   (PIX),
    .CPU_DIV   (CPU)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .btn_reset (btn_reset),
    .sys_rst_n (sys_rst_n),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .running   (running)
  );

  always #5 clk = ~clk;

  // Reference model: phase of operation, time spent in it, and age of the enable phase
  int m_st;
  int m_age;
  int m_en_age;
  bit m_lock_s, m_btn_s, m_db, m_db_prev;
  bit pll_h[$];
  bit btn_h[$];
  bit win[$];

  task automatic model_reset();
    m_st = S_WAIT; m_age = 0; m_en_age = 0;
    m_lock_s = 0; m_btn_s = 0; m_db = 0; m_db_prev = 0;
    pll_h.delete(); btn_h.delete(); win.delete();
  endtask

  task automatic model_edge();
    bit l, p, all;
    l = m_lock_s;
    p = m_db && !m_db_prev;
    case (m_st)
      S_WAIT:   if (l) begin m_st = S_SETTLE; m_age = 0; end
      S_SETTLE: if (!l) m_st = S_WAIT;
                else if (m_age == int'(LW) - 1) begin m_st = S_HOLD; m_age = 0; m_en_age = 0; end
                else m_age++;
      S_HOLD:   if (!l) m_st = S_WAIT;
                else begin
                  m_en_age++;
                  if (m_age == int'(RH) - 1) m_st = S_RUN; else m_age++;
                end
      default:  if (!l) m_st = S_WAIT;
                else if (p) begin m_st = S_HOLD; m_age = 0; m_en_age = 0; end
                else m_en_age++;
    endcase
    // Accept a new button level once the last DEB samples all agree on it
    win.push_back(m_btn_s);
    if (win.size() > DEB) void'(win.pop_front());
    m_db_prev = m_db;
    if (win.size() == DEB) begin
      all = 1;
      foreach (win[i]) if (win[i] != win[0]) all = 0;
      if (all && (win[0] != m_db)) m_db = win[0];
    end
    // Synchronized values lag the pin by three edges
    pll_h.push_front(pll_locked);
    btn_h.push_front(btn_reset);
    if (pll_h.size() > 3) void'(pll_h.pop_back());
    if (btn_h.size() > 3) void'(btn_h.pop_back());
    m_lock_s = (pll_h.size() == 3) ? pll_h[2] : 1'b0;
    m_btn_s  = (btn_h.size() == 3) ? btn_h[2] : 1'b0;
  endtask

  function automatic logic exp_run();
    return (m_st == S_RUN);
  endfunction

  function automatic logic exp_ce(input int div);
    return ((m_st == S_HOLD) || (m_st == S_RUN)) && (m_en_age > 0) && ((m_en_age % div) == 0);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b, want %b", name, edge_no, act, exp);
    end
  endtask

  // One clock edge: advance model, then compare outputs on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    edge_no++;
    @(negedge clk);
    check("model sys_rst_n", sys_rst_n, exp_run());
    check("model running", running, exp_run());
    check("model ce_pix", ce_pix, exp_ce(int'(PIX)));
    check("model ce_cpu", ce_cpu, exp_ce(int'(CPU)));
  endtask

  task automatic step_to(input int e);
    while (edge_no < e) tick();
  endtask

  typedef struct {
    int   e;
    logic pll;
    logic rst;
    logic pix;
    logic cpu;
    logic run;
  } vec_t;

  vec_t vt[14];

  initial begin
    // Power-up and lock loss: edge numbers count from the lock rise
    vt[0]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{17, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{19, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[10] = '{21, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[11] = '{22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[12] = '{23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    model_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("reset sys_rst_n", sys_rst_n, 1'b0);
    check("reset ce_pix", ce_pix, 1'b0);
    check("reset ce_cpu", ce_cpu, 1'b0);
    check("reset running", running, 1'b0);
    rst_n = 1'b1;
    edge_no = -1;

    for (int i = 0; i < 14; i++) begin
      pll_locked = vt[i].pll;
      step_to(vt[i].e);
      check($sformatf("vec%0d sys_rst_n", i), sys_rst_n, vt[i].rst);
      check($sformatf("vec%0d ce_pix", i), ce_pix, vt[i].pix);
      check($sformatf("vec%0d ce_cpu", i), ce_cpu, vt[i].cpu);
      check($sformatf("vec%0d running", i), running, vt[i].run);
    end

    // Lock glitch mid-SETTLE restarts the full count from the re-rise
    edge_no = -1;
    pll_locked = 1'b1;
    step_to(6);
    pll_locked = 1'b0;
    step_to(9);
    pll_locked = 1'b1;
    edge_no = -1;
    step_to(14);
    check("glitch still in reset", sys_rst_n, 1'b0);
    tick();
    check("glitch release", sys_rst_n, 1'b1);

    // Bouncing button in RUN must not reset
    for (int i = 0; i < 8; i++) begin
      btn_reset = ~btn_reset;
      repeat (5) begin
        tick();
        check("bounce sys_rst_n", sys_rst_n, 1'b1);
      end
    end
    btn_reset = 1'b1;
    edge_no = -1;
    step_to(18);
    check("press not yet", sys_rst_n, 1'b1);
    tick();
    check("press reset", sys_rst_n, 1'b0);
    step_to(22);
    check("press hold", sys_rst_n, 1'b0);
    tick();
    check("press release", sys_rst_n, 1'b1);
    check("press ce_cpu", ce_cpu, 1'b1);
    step_to(40);
    check("held button no re-reset", sys_rst_n, 1'b1);
    btn_reset = 1'b0;
    repeat (30) tick();

    // Press and lock loss on the same edge: lock loss wins
    btn_reset = 1'b1;
    edge_no = -1;
    step_to(15);
    pll_locked = 1'b0;
    step_to(18);
    check("simul before", running, 1'b1);
    tick();
    check("simul sys_rst_n", sys_rst_n, 1'b0);
    check("simul ce_pix", ce_pix, 1'b0);
    tick();
    check("simul ce_pix next", ce_pix, 1'b0);
    step_to(24);
    pll_locked = 1'b1;
    edge_no = -1;
    step_to(14);
    check("simul relock wait", sys_rst_n, 1'b0);
    tick();
    check("simul relock release", sys_rst_n, 1'b1);

    // Async reset between edges clears outputs immediately
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async sys_rst_n", sys_rst_n, 1'b0);
    check("async running", running, 1'b0);
    check("async ce_pix", ce_pix, 1'b0);
    check("async ce_cpu", ce_cpu, 1'b0);
    model_reset();
    tick();
    rst_n = 1'b1;
    edge_no = -1;
    step_to(14);
    check("async restart wait", sys_rst_n, 1'b0);
    tick();
    check("async restart release", sys_rst_n, 1'b1);

    // Random lock and button activity against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) pll_locked = ~pll_locked;
      if ($urandom_range(0, 19) == 0) btn_reset = ~btn_reset;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
